// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: MDU opcodes and default busy lengths shared by the E-stage multiply/divide unit
package e_mdu_pkg;
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_e;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES = 10;
endpackage

// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit owning HI/LO, with a fixed-latency Busy window
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Out
);
  logic [3:0] cnt;
  logic [31:0] res_hi, res_lo, ua, ub, uq, ur;
  logic [63:0] prod;
  logic keep, is_mul, is_div, ext, a_neg, b_neg, b_zero;
  always_comb begin
    is_mul = MDUOp == OP_MULT || MDUOp == OP_MULTU;
    is_div = MDUOp == OP_DIV || MDUOp == OP_DIVU;
    ext = MDUOp == OP_MULT;
    prod = {{32{ext & A[31]}}, A} * {{32{ext & B[31]}}, B};
    a_neg = MDUOp == OP_DIV && A[31];
    b_neg = MDUOp == OP_DIV && B[31];
    b_zero = B == 32'd0;
    // Signed divide on magnitudes: also yields 0x80000000/-1 = 0x80000000 without overflow
    ua = a_neg ? -A : A;
    ub = b_zero ? 32'd1 : b_neg ? -B : B;
    uq = ua / ub;
    ur = ua % ub;
    Out = MDUOp == OP_MFHI ? HI : MDUOp == OP_MFLO ? LO : 32'd0;
  end
  assign Busy = cnt != 4'd0;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt <= 4'd0;
      HI <= 32'd0;
      LO <= 32'd0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
      keep <= 1'b0;
    end else if (Busy) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1 && !keep) begin
        HI <= res_hi;
        LO <= res_lo;
      end
    end else if (Start && (is_mul || is_div)) begin
      cnt <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
      res_hi <= is_mul ? prod[63:32] : a_neg ? -ur : ur;
      res_lo <= is_mul ? prod[31:0] : (a_neg ^ b_neg) ? -uq : uq;
      keep <= is_div && b_zero;
    end else if (MDUOp == OP_MTHI) begin
      HI <= A;
    end else if (MDUOp == OP_MTLO) begin
      LO <= A;
    end
  end
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: randomized and directed checks of e_mdu against a plain-arithmetic HI/LO model
module tb_e_mdu;
  localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
  localparam logic [3:0] MFHI = 4'd5, MFLO = 4'd6, MTHI = 4'd7, MTLO = 4'd8;
  logic Clk = 0, Reset = 0, Start = 0;
  logic [3:0] MDUOp = 0;
  logic [31:0] A = 0, B = 0;
  logic Busy;
  logic [31:0] HI, LO, Out;
  int checks = 0, errors = 0;
  int m_left = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  bit p_keep = 0;
  always #5 Clk = ~Clk;
  e_mdu dut (.Clk(Clk), .Reset(Reset), .Start(Start), .MDUOp(MDUOp), .A(A), .B(B),
             .Busy(Busy), .HI(HI), .LO(LO), .Out(Out));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model_edge(input logic s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    p = '0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && !p_keep) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (s && op >= MULT && op <= DIVU) begin
      m_left = (op <= MULTU) ? 5 : 10;
      p_keep = 0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (op == MULT) p = 64'(sa * sb);
      else if (op == MULTU) p = 64'(a) * 64'(b);
      else if (b == 0) p_keep = 1;
      else if (op == DIV) p = {32'(sa % sb), 32'(sa / sb)};
      else p = {a % b, a / b};
      p_hi = p[63:32];
      p_lo = p[31:0];
    end else if (op == MTHI) m_hi = a;
    else if (op == MTLO) m_lo = a;
  endtask
  task automatic step(input logic s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = s;
    MDUOp = op;
    A = a;
    B = b;
    #1 chk("out", Out, op == MFHI ? m_hi : op == MFLO ? m_lo : 32'h0);
    @(posedge Clk);
    model_edge(s, op, a, b);
    @(negedge Clk);
    chk("busy", 32'(Busy), 32'(m_left != 0));
    chk("hi", HI, m_hi);
    chk("lo", LO, m_lo);
    Start = 0;
  endtask
  task automatic drain(output int n);
    n = 0;
    while (Busy && n < 40) begin
      n++;
      step(0, NONE, $urandom, $urandom);
    end
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    #2 Reset = 1;
    #1;
    chk("rst_busy", 32'(Busy), 32'h0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    @(negedge Clk);
    Reset = 0;
    step(1, MULT, 32'hFFFFFFFF, 32'd2);
    drain(n);
    chk("mult_len", 32'(n), 32'd5);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFE);
    step(1, MULTU, 32'hFFFFFFFF, 32'd2);
    drain(n);
    chk("multu_len", 32'(n), 32'd5);
    chk("multu_hi", HI, 32'h00000001);
    chk("multu_lo", LO, 32'hFFFFFFFE);
    step(1, DIV, 32'hFFFFFFF9, 32'd2);
    drain(n);
    chk("div_len", 32'(n), 32'd10);
    chk("div_hi", HI, 32'hFFFFFFFF);
    chk("div_lo", LO, 32'hFFFFFFFD);
    step(1, DIVU, 32'd7, 32'd2);
    drain(n);
    chk("divu_hi", HI, 32'd1);
    chk("divu_lo", LO, 32'd3);
    step(1, DIV, 32'h80000000, 32'hFFFFFFFF);
    drain(n);
    chk("divovf_hi", HI, 32'h0);
    chk("divovf_lo", LO, 32'h80000000);
    step(0, MTHI, 32'h12345678, 32'h0);
    MDUOp = MFHI;
    #1 chk("mfhi", Out, 32'h12345678);
    step(0, MFHI, 32'h0, 32'h0);
    step(0, MTHI, 32'hAA, 32'h0);
    step(0, MTLO, 32'hBB, 32'h0);
    step(1, DIV, 32'd5, 32'd0);
    n = 0;
    while (Busy && n < 40) begin
      n++;
      if (n == 3) step(1, MULT, 32'd3, 32'd4);
      else if (n == 5) step(0, MTLO, 32'hDEAD, 32'h0);
      else step(0, NONE, 32'h0, 32'h0);
    end
    chk("div0_len", 32'(n), 32'd10);
    chk("div0_hi", HI, 32'hAA);
    chk("div0_lo", LO, 32'hBB);
    step(1, MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (3) step(0, NONE, 32'h0, 32'h0);
    Reset = 1;
    #1;
    m_left = 0;
    m_hi = 0;
    m_lo = 0;
    chk("mid_rst_busy", 32'(Busy), 32'h0);
    chk("mid_rst_hi", HI, 32'h0);
    chk("mid_rst_lo", LO, 32'h0);
    #2 Reset = 0;
    step(1, MULT, 32'd3, 32'd4);
    drain(n);
    chk("post_rst_hi", HI, 32'h0);
    chk("post_rst_lo", LO, 32'd12);
    repeat (400) step(logic'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), pick(), pick());
    drain(n);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
